// File: rtl/phv_pkg.sv
// rtl/phv_pkg.sv - shared types, widths and PHV field offsets for the PHV assembler
package phv_pkg;

    localparam int CONT_PER_TYPE = 8;
    localparam int IDX_W         = 3;
    localparam int VAL_IN_LEN    = 64;

    localparam int W_2B = 16;
    localparam int W_4B = 32;
    localparam int W_8B = 64;

    localparam int OFF_2B  = 0;
    localparam int OFF_4B  = OFF_2B + CONT_PER_TYPE * W_2B;
    localparam int OFF_8B  = OFF_4B + CONT_PER_TYPE * W_4B;
    localparam int PHV_LEN = OFF_8B + CONT_PER_TYPE * W_8B;

    localparam logic [1:0] TYPE_NONE = 2'b00;
    localparam logic [1:0] TYPE_2B   = 2'b01;
    localparam logic [1:0] TYPE_4B   = 2'b10;
    localparam logic [1:0] TYPE_8B   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

endpackage

// File: rtl/phv_container_bank.sv
// rtl/phv_container_bank.sv - one type's set of containers with write mask and duplicate detect
module phv_container_bank
    import phv_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                       clk,
    input  logic                       aresetn,
    input  logic                       wr_en,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic [W-1:0]               wr_data,
    input  logic                       clr,
    output logic [CONT_PER_TYPE*W-1:0] data,
    output logic [CONT_PER_TYPE-1:0]   mask,
    output logic                       dup
);

    logic [W-1:0] regs [CONT_PER_TYPE];

    // Clear only happens in HOLD, where writes are already blocked upstream.
    always_ff @(posedge clk) begin
        if (!aresetn || clr) begin
            for (int i = 0; i < CONT_PER_TYPE; i++) begin
                regs[i] <= '0;
            end
            mask <= '0;
        end else if (wr_en) begin
            regs[wr_idx] <= wr_data;
            mask[wr_idx] <= 1'b1;
        end
    end

    assign dup = wr_en && mask[wr_idx];

    for (genvar g = 0; g < CONT_PER_TYPE; g++) begin : g_pack
        assign data[g*W +: W] = regs[g];
    end

endmodule

// File: rtl/phv_assembler.sv
// rtl/phv_assembler.sv - gathers typed parser values into a PHV and hands it off on valid/ready
module phv_assembler
    import phv_pkg::*;
(
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  val_in_valid,
    input  logic [VAL_IN_LEN-1:0] val_in,
    input  logic [1:0]            val_in_type,
    input  logic [IDX_W-1:0]      val_in_seq,
    input  logic                  sub_seg_valid,
    input  logic                  hdr_done,
    output logic                  busy,
    output logic                  phv_valid,
    input  logic                  phv_ready,
    output logic [PHV_LEN-1:0]    phv_out,
    output logic [23:0]           phv_mask,
    output logic [7:0]            seg_cnt,
    output logic                  dup_err,
    output logic                  drop_err
);

    state_t state, state_nxt;

    logic collecting;
    logic accept;
    logic wr_2b, wr_4b, wr_8b, any_wr;
    logic dup_2b, dup_4b, dup_8b;
    logic [CONT_PER_TYPE-1:0] mask_2b, mask_4b, mask_8b;

    assign collecting = (state != ST_HOLD);
    assign accept     = (state == ST_HOLD) && phv_ready;

    assign wr_2b  = collecting && val_in_valid && (val_in_type == TYPE_2B);
    assign wr_4b  = collecting && val_in_valid && (val_in_type == TYPE_4B);
    assign wr_8b  = collecting && val_in_valid && (val_in_type == TYPE_8B);
    assign any_wr = wr_2b || wr_4b || wr_8b;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (hdr_done)    state_nxt = ST_HOLD;
                else if (any_wr) state_nxt = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (hdr_done) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (phv_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!aresetn) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Both handshake outputs decode straight from the state register.
    assign phv_valid = (state == ST_HOLD);
    assign busy      = (state == ST_HOLD);

    always_ff @(posedge clk) begin
        if (!aresetn || accept) begin
            seg_cnt <= '0;
        end else if (collecting && sub_seg_valid && seg_cnt != 8'hFF) begin
            seg_cnt <= seg_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            dup_err  <= 1'b0;
            drop_err <= 1'b0;
        end else begin
            if (dup_2b || dup_4b || dup_8b) dup_err <= 1'b1;
            if (!collecting && val_in_valid && val_in_type != TYPE_NONE) drop_err <= 1'b1;
        end
    end

    phv_container_bank #(.W(W_2B)) u_bank_2b (
        .clk     (clk),
        .aresetn (aresetn),
        .wr_en   (wr_2b),
        .wr_idx  (val_in_seq),
        .wr_data (val_in[W_2B-1:0]),
        .clr     (accept),
        .data    (phv_out[OFF_4B-1:OFF_2B]),
        .mask    (mask_2b),
        .dup     (dup_2b)
    );

    phv_container_bank #(.W(W_4B)) u_bank_4b (
        .clk     (clk),
        .aresetn (aresetn),
        .wr_en   (wr_4b),
        .wr_idx  (val_in_seq),
        .wr_data (val_in[W_4B-1:0]),
        .clr     (accept),
        .data    (phv_out[OFF_8B-1:OFF_4B]),
        .mask    (mask_4b),
        .dup     (dup_4b)
    );

    phv_container_bank #(.W(W_8B)) u_bank_8b (
        .clk     (clk),
        .aresetn (aresetn),
        .wr_en   (wr_8b),
        .wr_idx  (val_in_seq),
        .wr_data (val_in[W_8B-1:0]),
        .clr     (accept),
        .data    (phv_out[PHV_LEN-1:OFF_8B]),
        .mask    (mask_8b),
        .dup     (dup_8b)
    );

    assign phv_mask = {mask_8b, mask_4b, mask_2b};

endmodule
